// File: rtl/instruction_fetch_if.sv
// Bus bundle between the fetch unit and its memory/decoder environment.
// master: the fetch unit; slave: memory port plus instruction consumer.
interface instruction_fetch_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [7:0]  mem_data;
  logic        halt;
  logic [15:0] word;
  logic        word_valid;
  logic        word_ack;
  logic        jump_rel;
  logic [7:0]  rel_addr;
  logic        jump_abs;
  logic [15:0] abs_addr;
  logic [15:0] pc;

  modport master (
    output mem_addr, mem_rd, word, word_valid, pc,
    input  mem_ready, mem_data, halt, word_ack, jump_rel, rel_addr, jump_abs, abs_addr
  );

  modport slave (
    input  mem_addr, mem_rd, word, word_valid, pc,
    output mem_ready, mem_data, halt, word_ack, jump_rel, rel_addr, jump_abs, abs_addr
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetches 16-bit little-endian instructions one byte at a time from an 8-bit
// memory port and holds each word until the consumer retires it, with redirects.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam logic [AW-1:0] PC_INIT = RESET_PC & 16'hFFFE;

  typedef enum logic [1:0] {
    FETCH_LO = 2'd0,
    FETCH_HI = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_pc;
  logic [2*DW-1:0] r_word;
  logic            w_lo_take;
  logic            w_hi_take;
  logic            w_retire;
  logic [AW-1:0]   w_rel_off;
  logic [AW-1:0]   w_pc_seq;
  logic [AW-1:0]   w_pc_nxt;
  logic            w_mem_rd;
  logic [AW-1:0]   w_mem_addr;
  logic            w_word_valid;

  // A byte is consumed only while its read is actually requested.
  assign w_lo_take = (r_state == FETCH_LO) && !bus.halt && bus.mem_ready;
  assign w_hi_take = (r_state == FETCH_HI) && bus.mem_ready;
  assign w_retire  = (r_state == HOLD) && bus.word_ack;

  // Word offset scaled to bytes; absolute target forced even.
  assign w_rel_off = {{(AW-DW-1){bus.rel_addr[DW-1]}}, bus.rel_addr, 1'b0};
  assign w_pc_seq  = r_pc + AW'(2);
  assign w_pc_nxt  = bus.jump_abs ? (bus.abs_addr & 16'hFFFE) :
                     bus.jump_rel ? (w_pc_seq + w_rel_off) : w_pc_seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH_LO;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH_LO: if (w_lo_take) w_state_nxt = FETCH_HI;
      FETCH_HI: if (w_hi_take) w_state_nxt = HOLD;
      HOLD:     if (w_retire)  w_state_nxt = FETCH_LO;
      default:  w_state_nxt = FETCH_LO;
    endcase
  end

  // Memory request follows halt combinationally so a halted fetch never issues.
  always_comb begin
    w_mem_rd     = 1'b0;
    w_mem_addr   = '0;
    w_word_valid = 1'b0;
    if (!rst) begin
      case (r_state)
        FETCH_LO: begin
          w_mem_addr = r_pc;
          w_mem_rd   = !bus.halt;
        end
        FETCH_HI: begin
          w_mem_addr = r_pc + AW'(1);
          w_mem_rd   = 1'b1;
        end
        HOLD: begin
          w_mem_addr   = r_pc;
          w_word_valid = 1'b1;
        end
        default: begin
          w_mem_addr = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= PC_INIT;
      r_word <= '0;
    end else begin
      if (w_lo_take) r_word[DW-1:0]    <= bus.mem_data;
      if (w_hi_take) r_word[2*DW-1:DW] <= bus.mem_data;
      if (w_retire)  r_pc              <= w_pc_nxt;
    end
  end

  assign bus.mem_rd     = w_mem_rd;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.word_valid = w_word_valid;
  assign bus.word       = r_word;
  assign bus.pc         = r_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a byte-count transaction model checked
// every cycle, plus literal expectations; a second instance exercises wrap-around.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] garble;
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instruction_fetch_if if1 ();
  instruction_fetch_if if2 ();

  instruction_fetch #(.RESET_PC(16'h0000)) u_dut (.clk(clk), .rst(rst), .bus(if1));
  instruction_fetch #(.RESET_PC(16'hFFFF)) u_wrap (.clk(clk), .rst(rst), .bus(if2));

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0000: return 8'h1C;
      16'h0001: return 8'hA5;
      16'h0002: return 8'h03;
      16'h0003: return 8'h40;
      default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  assign if1.mem_data  = mem_byte(if1.mem_addr) ^ garble;
  assign if2.mem_data  = mem_byte(if2.mem_addr);
  assign if2.mem_ready = 1'b1;
  assign if2.halt      = 1'b0;
  assign if2.word_ack  = if2.word_valid;
  assign if2.jump_rel  = 1'b0;
  assign if2.rel_addr  = 8'h00;
  assign if2.jump_abs  = 1'b0;
  assign if2.abs_addr  = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Model: bytes received so far for the instruction at m_pc (2 = word complete).
  logic [15:0] m_pc;
  int          m_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc  <= 16'h0000;
      m_idx <= 0;
    end else if (m_idx == 0) begin
      if (!if1.halt && if1.mem_ready) m_idx <= 1;
    end else if (m_idx == 1) begin
      if (if1.mem_ready) m_idx <= 2;
    end else if (if1.word_ack) begin
      m_idx <= 0;
      if (if1.jump_abs)
        m_pc <= if1.abs_addr & 16'hFFFE;
      else if (if1.jump_rel)
        m_pc <= 16'(int'(m_pc) + 2 + 2 * int'($signed(if1.rel_addr)));
      else
        m_pc <= m_pc + 16'd2;
    end
  end

  always @(negedge clk) begin
    logic        exp_rd;
    logic [15:0] exp_addr;
    if (rst) begin
      chk("rst_mem_rd", if1.mem_rd, 1'b0);
      chk("rst_mem_addr", if1.mem_addr, 16'h0000);
      chk("rst_word", if1.word, 16'h0000);
      chk("rst_word_valid", if1.word_valid, 1'b0);
      chk("rst_pc", if1.pc, 16'h0000);
    end else begin
      exp_rd   = (m_idx == 1) || (m_idx == 0 && !if1.halt);
      exp_addr = m_pc + 16'(m_idx);
      chk("cmp_word_valid", if1.word_valid, m_idx == 2);
      chk("cmp_pc", if1.pc, m_pc);
      chk("cmp_mem_rd", if1.mem_rd, exp_rd);
      if (exp_rd) chk("cmp_mem_addr", if1.mem_addr, exp_addr);
      if (m_idx == 2) chk("cmp_word", if1.word, {mem_byte(m_pc + 16'd1), mem_byte(m_pc)});
    end
  end

  logic [15:0] q_addr[$];
  logic [15:0] q_wpc[$];
  logic [15:0] q_word[$];
  int          q_cyc[$];

  always @(negedge clk) begin
    if (rst) begin
      q_addr.delete();
      q_wpc.delete();
      q_word.delete();
      q_cyc.delete();
    end else begin
      if (if2.mem_rd) q_addr.push_back(if2.mem_addr);
      if (if2.word_valid) begin
        q_wpc.push_back(if2.pc);
        q_word.push_back(if2.word);
        q_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm, input int exp_cycles);
    int n = 0;
    while (!if1.word_valid && n < 30) begin
      tick();
      n++;
    end
    chk(nm, n, exp_cycles);
  endtask

  task automatic retire(input logic jr, input logic [7:0] rel, input logic ja, input logic [15:0] abs);
    if1.word_ack = 1'b1;
    if1.jump_rel = jr;
    if1.rel_addr = rel;
    if1.jump_abs = ja;
    if1.abs_addr = abs;
    tick();
    if1.word_ack = 1'b0;
    if1.jump_rel = 1'b0;
    if1.rel_addr = 8'h00;
    if1.jump_abs = 1'b0;
    if1.abs_addr = 16'h0000;
  endtask

  initial begin
    rst           = 1'b1;
    garble        = 8'h00;
    if1.mem_ready = 1'b1;
    if1.halt      = 1'b0;
    if1.word_ack  = 1'b0;
    if1.jump_rel  = 1'b0;
    if1.rel_addr  = 8'h00;
    if1.jump_abs  = 1'b0;
    if1.abs_addr  = 16'h0000;
    repeat (3) tick();
    rst = 1'b0;

    // Sequential fetch from address 0
    wait_valid("seq_lat0", 2);
    chk("seq_word0", if1.word, 16'hA51C);
    chk("seq_pc0", if1.pc, 16'h0000);
    retire(1'b0, 8'h00, 1'b0, 16'h0000);
    wait_valid("seq_lat1", 2);
    chk("seq_word1", if1.word, 16'h4003);
    chk("seq_pc1", if1.pc, 16'h0002);
    retire(1'b0, 8'h00, 1'b0, 16'h0000);

    // Three wait states per byte; ack/jump outside HOLD must be ignored
    begin
      int n = 0;
      while (!if1.word_valid && n < 30) begin
        if1.mem_ready = (n % 4 == 3);
        if1.word_ack  = 1'b1;
        if1.jump_abs  = 1'b1;
        if1.abs_addr  = 16'hBEEF;
        tick();
        n++;
      end
      if1.word_ack = 1'b0;
      if1.jump_abs = 1'b0;
      if1.abs_addr = 16'h0000;
      chk("wait_lat", n, 8);
    end
    chk("wait_word", if1.word, 16'h5F5E);
    chk("wait_pc", if1.pc, 16'h0004);

    // Stray ready with corrupted data while holding
    garble        = 8'hFF;
    if1.mem_ready = 1'b1;
    repeat (2) tick();
    chk("hold_word", if1.word, 16'h5F5E);
    garble = 8'h00;

    // Wrap-around instance (RESET_PC bit 0 set, forced even)
    chk("wrap_naddr", q_addr.size() >= 4, 1'b1);
    chk("wrap_nword", q_wpc.size() >= 2, 1'b1);
    if (q_addr.size() >= 4) begin
      chk("wrap_addr0", q_addr[0], 16'hFFFE);
      chk("wrap_addr1", q_addr[1], 16'hFFFF);
      chk("wrap_addr2", q_addr[2], 16'h0000);
      chk("wrap_addr3", q_addr[3], 16'h0001);
    end
    if (q_wpc.size() >= 2) begin
      chk("wrap_pc0", q_wpc[0], 16'hFFFE);
      chk("wrap_word0", q_word[0], 16'h5A5B);
      chk("wrap_pc1", q_wpc[1], 16'h0000);
      chk("wrap_word1", q_word[1], 16'hA51C);
      chk("wrap_period", q_cyc[1] - q_cyc[0], 3);
    end

    // Redirects
    retire(1'b0, 8'h00, 1'b1, 16'h0010);
    wait_valid("jabs_lat", 2);
    chk("jabs_pc", if1.pc, 16'h0010);
    retire(1'b1, 8'hFE, 1'b0, 16'h0000);
    wait_valid("jrel_lat", 2);
    chk("jrel_pc", if1.pc, 16'h000E);
    chk("jrel_word", if1.word, 16'h5554);
    retire(1'b1, 8'h7F, 1'b1, 16'h1235);
    wait_valid("jpri_lat", 2);
    chk("jpri_pc", if1.pc, 16'h1234);
    retire(1'b1, 8'h03, 1'b0, 16'h0000);
    wait_valid("jfwd_lat", 2);
    chk("jfwd_pc", if1.pc, 16'h123C);

    // Halt in FETCH_LO blocks progress, even with ready and junk data
    if1.halt = 1'b1;
    retire(1'b0, 8'h00, 1'b0, 16'h0000);
    garble = 8'hFF;
    repeat (3) tick();
    chk("halt_rd", if1.mem_rd, 1'b0);
    chk("halt_valid", if1.word_valid, 1'b0);
    chk("halt_pc", if1.pc, 16'h123E);
    garble   = 8'h00;
    if1.halt = 1'b0;
    wait_valid("halt_resume", 2);

    // Halt raised after FETCH_HI is entered has no effect
    retire(1'b0, 8'h00, 1'b0, 16'h0000);
    tick();
    if1.halt = 1'b1;
    wait_valid("halt_hi", 1);
    chk("halt_hi_pc", if1.pc, 16'h1240);
    if1.halt = 1'b0;

    // Reset mid-FETCH_HI
    retire(1'b0, 8'h00, 1'b0, 16'h0000);
    tick();
    if1.mem_ready = 1'b0;
    tick();
    chk("pre_rst_rd", if1.mem_rd, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_rd", if1.mem_rd, 1'b0);
    chk("arst_addr", if1.mem_addr, 16'h0000);
    chk("arst_word", if1.word, 16'h0000);
    chk("arst_pc", if1.pc, 16'h0000);
    tick();
    tick();
    rst           = 1'b0;
    if1.mem_ready = 1'b1;
    #1;
    chk("post_rst_rd", if1.mem_rd, 1'b1);
    chk("post_rst_addr", if1.mem_addr, 16'h0000);
    wait_valid("post_rst_lat", 2);
    chk("post_rst_word", if1.word, 16'hA51C);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
